// File: rtl/armleobus_arbiter2.sv
// Two-requester armleobus arbiter: PTW (req0) and cache refill (req1) share one master port.
// Ties go to req0 unless ARMLEOBUS_ARB_ROUND_ROBIN_EN is defined, which alternates them.
module armleobus_arbiter2 #(
  parameter int ADDR_W = 34,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                s_transaction,
  input  logic [5:0]                s_cmd,
  input  logic [2*ADDR_W-1:0]       s_address,
  input  logic [2*DATA_W-1:0]       s_wdata,
  input  logic [2*(DATA_W/8)-1:0]   s_wbyte_enable,
  output logic [1:0]                s_transaction_done,
  output logic [2:0]                s_transaction_response,
  output logic [DATA_W-1:0]         s_rdata,
  output logic                      m_transaction,
  output logic [2:0]                m_cmd,
  output logic [ADDR_W-1:0]         m_address,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W/8-1:0]       m_wbyte_enable,
  input  logic                      m_transaction_done,
  input  logic [2:0]                m_transaction_response,
  input  logic [DATA_W-1:0]         m_rdata,
  output logic [1:0]                grant_debug
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   tie_to1;

`ifdef ARMLEOBUS_ARB_ROUND_ROBIN_EN
  assign tie_to1 = ~last_grant;
`else
  assign tie_to1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt              = state;
    last_grant_nxt         = last_grant;
    m_transaction          = 1'b0;
    m_cmd                  = '0;
    m_address              = '0;
    m_wdata                = '0;
    m_wbyte_enable         = '0;
    s_transaction_done     = 2'b00;
    grant_debug            = 2'b00;
    s_transaction_response = m_transaction_response;
    s_rdata                = m_rdata;
    case (state)
      IDLE: begin
        if (s_transaction[0] && !(s_transaction[1] && tie_to1))
          state_nxt = GRANT0;
        else if (s_transaction[1])
          state_nxt = GRANT1;
      end
      GRANT0: begin
        grant_debug           = 2'b01;
        m_transaction         = s_transaction[0];
        m_cmd                 = s_cmd[2:0];
        m_address             = s_address[ADDR_W-1:0];
        m_wdata               = s_wdata[DATA_W-1:0];
        m_wbyte_enable        = s_wbyte_enable[BE_W-1:0];
        s_transaction_done[0] = m_transaction_done;
        if (m_transaction_done) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end
      GRANT1: begin
        grant_debug           = 2'b10;
        m_transaction         = s_transaction[1];
        m_cmd                 = s_cmd[5:3];
        m_address             = s_address[2*ADDR_W-1:ADDR_W];
        m_wdata               = s_wdata[2*DATA_W-1:DATA_W];
        m_wbyte_enable        = s_wbyte_enable[2*BE_W-1:BE_W];
        s_transaction_done[1] = m_transaction_done;
        if (m_transaction_done) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A granted requester must keep its request up until the downstream done.
  always_ff @(posedge clk) begin
    if (!rst && !m_transaction_done &&
        ((state == GRANT0 && !s_transaction[0]) || (state == GRANT1 && !s_transaction[1])))
      $error("armleobus_arbiter2: granted requester dropped s_transaction before done");
  end

  assert property (@(posedge clk) disable iff (rst)
    (state == GRANT1 && m_transaction_done) |=> last_grant);
  assert property (@(posedge clk) disable iff (rst)
    (state == GRANT0 && m_transaction_done) |=> !last_grant);

endmodule

// File: tb/tb_armleobus_arbiter2.sv
// Scoreboard bench for armleobus_arbiter2: memory-slave model, per-requester expectation queues.
module tb_armleobus_arbiter2;
  localparam int ADDR_W = 34;
  localparam int DATA_W = 32;
  localparam logic [2:0] CMD_READ = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] RESP_SUCCESS = 3'd0;
  localparam logic [2:0] RESP_UNKNOWN_ADDRESS = 3'd3;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] tr;
  logic [1:0][2:0] cmd_r;
  logic [1:0][ADDR_W-1:0] addr_r;
  logic [1:0][DATA_W-1:0] wdata_r;
  logic [1:0][3:0] be_r;
  logic [1:0] s_transaction_done;
  logic [2:0] s_transaction_response;
  logic [DATA_W-1:0] s_rdata;
  logic m_transaction;
  logic [2:0] m_cmd;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0] m_wbyte_enable;
  logic m_done;
  logic [2:0] m_resp;
  logic [DATA_W-1:0] m_rd;
  logic [1:0] grant_debug;

  armleobus_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_transaction(tr), .s_cmd(cmd_r), .s_address(addr_r), .s_wdata(wdata_r),
    .s_wbyte_enable(be_r),
    .s_transaction_done(s_transaction_done), .s_transaction_response(s_transaction_response),
    .s_rdata(s_rdata),
    .m_transaction(m_transaction), .m_cmd(m_cmd), .m_address(m_address), .m_wdata(m_wdata),
    .m_wbyte_enable(m_wbyte_enable),
    .m_transaction_done(m_done), .m_transaction_response(m_resp), .m_rdata(m_rd),
    .grant_debug(grant_debug)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] arbq[$];
  int served[$];
  logic tb_last;
  logic [31:0] mem[128];
  logic [31:0] ref_mem[128];
  bit hold;
  bit force_idle_done;
  int lat_fixed;

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response is decided at issue time from the reference memory.
  task automatic issue(input int i, input logic [2:0] c, input logic [ADDR_W-1:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    int idx;
    idx = int'(a[8:2]);
    tr[i] = 1'b1; cmd_r[i] = c; addr_r[i] = a; wdata_r[i] = wd; be_r[i] = be;
    if (a[12]) e = '{rdata: 32'h0, resp: RESP_UNKNOWN_ADDRESS};
    else if (c == CMD_WRITE) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      e = '{rdata: 32'h0, resp: RESP_SUCCESS};
    end else e = '{rdata: ref_mem[idx], resp: RESP_SUCCESS};
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic rand_issue(input int i);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(i * 256 + 4 * $urandom_range(0, 63));
    if ($urandom_range(0, 9) == 0) a[12] = 1'b1;
    issue(i, ($urandom_range(0, 1) == 1) ? CMD_WRITE : CMD_READ, a, $urandom,
          4'($urandom_range(1, 15)));
  endtask

  task automatic wait_done(input int i, output int cyc, output logic [31:0] rd,
                           output logic [2:0] rs);
    cyc = 0; rd = '0; rs = '0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (s_transaction_done[i]) begin
        cyc = c; rd = s_rdata; rs = s_transaction_response;
        break;
      end
    end
    chk($sformatf("done%0d_seen", i), 64'(cyc != 0), 1);
    @(posedge clk); #1;
    tr[i] = 1'b0;
  endtask

  task automatic run_traffic(input int n0, input int n1, input int maxgap, input int budget);
    int left[2];
    int gap[2];
    bit busy[2];
    logic [1:0] d;
    left = '{n0, n1}; gap = '{0, 0}; busy = '{0, 0};
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      d = s_transaction_done;
      if (!busy[0] && !busy[1] && left[0] == 0 && left[1] == 0) break;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (busy[i] && d[i]) begin
          busy[i] = 0; tr[i] = 1'b0; gap[i] = $urandom_range(0, maxgap);
        end
        if (!busy[i] && left[i] > 0) begin
          if (gap[i] == 0) begin rand_issue(i); busy[i] = 1; left[i]--; end
          else gap[i]--;
        end
      end
    end
    chk("traffic_drained0", 64'(left[0] + int'(busy[0])), 0);
    chk("traffic_drained1", 64'(left[1] + int'(busy[1])), 0);
  endtask

  task automatic slave();
    bit busy = 0;
    int cnt = 0;
    logic [2:0] c;
    logic [ADDR_W-1:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    int idx;
    forever begin
      @(posedge clk); #2;
      m_done = 1'b0; m_rd = $urandom; m_resp = 3'($urandom);
      if (rst) begin busy = 0; continue; end
      if (force_idle_done && !m_transaction) m_done = 1'b1;
      if (!busy && m_transaction && !hold) begin
        busy = 1; cnt = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 2);
        c = m_cmd; a = m_address; wd = m_wdata; be = m_wbyte_enable;
      end
      if (busy && !hold) begin
        if (cnt == 0) begin
          busy = 0; m_done = 1'b1; idx = int'(a[8:2]);
          if (a[12]) begin m_resp = RESP_UNKNOWN_ADDRESS; m_rd = '0; end
          else if (c == CMD_WRITE) begin
            for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
            m_resp = RESP_SUCCESS; m_rd = '0;
          end else begin m_resp = RESP_SUCCESS; m_rd = mem[idx]; end
        end else cnt--;
      end
    end
  endtask

  task automatic monitor();
    logic [1:0] g;
    logic [1:0] w;
    exp_t e;
    bit have;
    int i;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete(); q1.delete(); arbq.delete(); tb_last = 1'b1;
        continue;
      end
      g = grant_debug;
      if (arbq.size() > 0) begin w = arbq.pop_front(); chk("arb_grant", 64'(g), 64'(w)); end
      if (g == 2'b00) begin
        chk("idle_m_txn", 64'(m_transaction), 0);
        chk("idle_m_addr", 64'(m_address), 0);
        chk("idle_m_cmd_be", 64'({m_cmd, m_wbyte_enable}), 0);
        chk("idle_m_wdata", 64'(m_wdata), 0);
        chk("idle_done", 64'(s_transaction_done), 0);
        if (tr != 2'b00) begin
          if (tr == 2'b11) begin
`ifdef ARMLEOBUS_ARB_ROUND_ROBIN_EN
            w = tb_last ? 2'b01 : 2'b10;
`else
            w = 2'b01;
`endif
          end else w = tr;
          arbq.push_back(w);
        end
      end else begin
        i = g[1] ? 1 : 0;
        chk("grant_onehot", 64'(g == 2'b01 || g == 2'b10), 1);
        chk("fwd_txn", 64'(m_transaction), 64'(tr[i]));
        chk("fwd_addr", 64'(m_address), 64'(addr_r[i]));
        chk("fwd_cmd", 64'(m_cmd), 64'(cmd_r[i]));
        chk("fwd_wdata", 64'(m_wdata), 64'(wdata_r[i]));
        chk("fwd_be", 64'(m_wbyte_enable), 64'(be_r[i]));
        chk("done_other_zero", 64'(s_transaction_done[1-i]), 0);
        chk("done_fwd", 64'(s_transaction_done[i]), 64'(m_done));
        if (s_transaction_done[i]) begin
          served.push_back(i); tb_last = i[0]; have = 0;
          if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
          if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
          chk("done_expected", 64'(have), 1);
          if (have) begin
            chk("done_rdata", 64'(s_rdata), 64'(e.rdata));
            chk("done_resp", 64'(s_transaction_response), 64'(e.resp));
          end
        end
      end
      chk("rdata_pass", 64'(s_rdata), 64'(m_rd));
      chk("resp_pass", 64'(s_transaction_response), 64'(m_resp));
    end
  endtask

  initial begin
    int cyc;
    int n1;
    logic [31:0] rd;
    logic [2:0] rs;
    rst = 1'b1; tr = '0; cmd_r = '0; addr_r = '0; wdata_r = '0; be_r = '0;
    m_done = 1'b0; m_resp = '0; m_rd = '0; hold = 0; force_idle_done = 0; lat_fixed = 0;
    tb_last = 1'b1;
    for (int k = 0; k < 128; k++) begin mem[k] = init_word(k); ref_mem[k] = init_word(k); end
    #1;
    chk("rst_grant", 64'(grant_debug), 0);
    chk("rst_m_txn", 64'(m_transaction), 0);
    chk("rst_done", 64'(s_transaction_done), 0);
    chk("rst_m_addr", 64'(m_address), 0);
    chk("rst_m_cmd_be", 64'({m_cmd, m_wbyte_enable}), 0);
    chk("rst_m_wdata", 64'(m_wdata), 0);
    fork
      monitor();
      slave();
    join_none
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Simultaneous first requests: req0 first, one idle cycle, then req1.
    @(posedge clk); #1;
    issue(0, CMD_READ, 34'h0, 0, 4'hf);
    issue(1, CMD_READ, 34'h100, 0, 4'hf);
    @(negedge clk); chk("tie_seq0", 64'(grant_debug), 64'(2'b00));
    @(negedge clk); chk("tie_seq1", 64'(grant_debug), 64'(2'b01));
    chk("tie_done0", 64'(s_transaction_done), 64'(2'b01));
    @(posedge clk); #1; tr[0] = 1'b0;
    @(negedge clk); chk("tie_seq2", 64'(grant_debug), 64'(2'b00));
    @(negedge clk); chk("tie_seq3", 64'(grant_debug), 64'(2'b10));
    chk("tie_done1", 64'(s_transaction_done), 64'(2'b10));
    @(posedge clk); #1; tr[1] = 1'b0;

    // Single req0 read at 0x4 with a one-cycle slave.
    lat_fixed = 1;
    @(posedge clk); #1;
    issue(0, CMD_READ, 34'h4, 0, 4'hf);
    @(negedge clk); chk("lat_before_grant", 64'(m_transaction), 0);
    @(negedge clk); chk("lat_m_txn", 64'(m_transaction), 1);
    chk("lat_no_early_done", 64'(s_transaction_done), 0);
    wait_done(0, cyc, rd, rs);
    chk("single_done_cycle", 64'(cyc), 1);
    chk("single_rdata", 64'(rd), 64'(init_word(1)));
    @(negedge clk); chk("single_back_idle", 64'(grant_debug), 0);

    // Error response on req1 completes its grant; pending req0 follows.
    lat_fixed = 2;
    @(posedge clk); #1;
    issue(1, CMD_READ, 34'h1104, 0, 4'hf);
    @(negedge clk); @(negedge clk);
    chk("err_grant1", 64'(grant_debug), 64'(2'b10));
    @(posedge clk); #1;
    issue(0, CMD_READ, 34'h8, 0, 4'hf);
    wait_done(1, cyc, rd, rs);
    chk("err_resp", 64'(rs), 64'(RESP_UNKNOWN_ADDRESS));
    wait_done(0, cyc, rd, rs);
    chk("after_err_rdata", 64'(rd), 64'(init_word(2)));
    chk("after_err_resp", 64'(rs), 64'(RESP_SUCCESS));

    // Reset during GRANT1 with the slave stalled.
    lat_fixed = 1;
    @(posedge clk); #1;
    hold = 1;
    issue(1, CMD_READ, 34'h108, 0, 4'hf);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_grant1", 64'(grant_debug), 64'(2'b10));
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("midrst_m_txn", 64'(m_transaction), 0);
    chk("midrst_grant", 64'(grant_debug), 0);
    chk("midrst_done", 64'(s_transaction_done), 0);
    chk("midrst_m_addr", 64'(m_address), 0);
    tr[1] = 1'b0;
    @(posedge clk); #1;
    issue(0, CMD_READ, 34'hC, 0, 4'hf);
    hold = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_grant0", 64'(grant_debug), 64'(2'b01));
    chk("postrst_m_txn", 64'(m_transaction), 1);
    wait_done(0, cyc, rd, rs);
    chk("postrst_rdata", 64'(rd), 64'(init_word(3)));

    // Done from the slave while idle is not forwarded.
    @(posedge clk); #1; force_idle_done = 1;
    @(negedge clk);
    chk("idle_done_ignored", 64'(s_transaction_done), 0);
    chk("idle_done_stay", 64'(grant_debug), 0);
    @(posedge clk); #1; force_idle_done = 0;

    // Both requesters back-to-back: starvation in fixed mode, alternation in round-robin.
    served.delete();
    lat_fixed = 0;
    run_traffic(10, 10, 0, 2000);
    n1 = 0;
    if (served.size() >= 10) for (int k = 0; k < 10; k++) n1 += served[k];
    chk("served_count", 64'(served.size()), 20);
`ifdef ARMLEOBUS_ARB_ROUND_ROBIN_EN
    chk("req1_in_first10", 64'(n1), 5);
    chk("req1_by_2nd", 64'(served.size() >= 2 && (served[0] == 1 || served[1] == 1)), 1);
`else
    chk("req1_in_first10", 64'(n1), 0);
`endif

    // Randomised traffic with random slave latency and error addresses.
    lat_fixed = -1;
    run_traffic(40, 40, 3, 8000);
    repeat (2) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 0);
    chk("q1_empty", 64'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
